// File: rtl/bus_fifo_pkg.sv
// Shared defaults and helpers for the parametrised bus FIFO.
package bus_fifo_pkg;

   localparam int WIDTH_DEF    = 8;
   localparam int DEPTH_DEF    = 32;
   localparam int AF_LEVEL_DEF = DEPTH_DEF - 4;
   localparam int AE_LEVEL_DEF = 4;

   function automatic int fifo_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, registered read.
module bus_fifo_mem
   import bus_fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rdata_q <= '0;
      else if (rd_en_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_fifo.sv
// Parametrised synchronous bus FIFO with status, error pulses and registered read.
// Optional watermark flags are built only when BUS_FIFO_WATERMARK_EN is defined.
module bus_fifo
   import bus_fifo_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AF_LEVEL = DEPTH - (DEPTH_DEF - AF_LEVEL_DEF),
   parameter int AE_LEVEL = AE_LEVEL_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic                     full,
   output logic                     empty,
   output logic [fifo_aw(DEPTH):0]  count,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = fifo_aw(DEPTH);
   localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        ovf_q, unf_q, dv_q;
   logic        wr_acc, rd_acc;

   // Extra wrap bit distinguishes full from empty when the addresses match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count = wr_ptr_q - rd_ptr_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
      rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= wr_en & full;
         unf_q    <= rd_en & empty;
         dv_q     <= rd_acc;
      end
   end

   assign overflow   = ovf_q;
   assign underflow  = unf_q;
   assign dout_valid = dv_q;

   bus_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (wr_acc),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (din),
      .rd_en_i (rd_acc),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (dout)
   );

`ifdef BUS_FIFO_WATERMARK_EN
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);
`else
   logic unused_wm;
   assign unused_wm    = ^{AF_CNT, AE_CNT};
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_bus_fifo.sv
// Scoreboard bench for bus_fifo (WIDTH=8, DEPTH=32): directed stimulus, queue-based checking.
module tb_bus_fifo;

   localparam int DEPTH = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [5:0] count;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q [$];   // expected dout values, in pop order
   logic [7:0] model [$];   // reference contents

   bus_fifo dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every dout_valid must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && dout_valid) begin
         if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
         else                   chk("dout", int'(dout), int'(exp_q.pop_front()));
      end
   end

   task automatic check_status();
      int n;
      n = model.size();
      chk("count", int'(count), n);
      chk("empty", int'(empty), int'(n == 0));
      chk("full",  int'(full),  int'(n == DEPTH));
`ifdef BUS_FIFO_WATERMARK_EN
      chk("almost_full",  int'(almost_full),  int'(n >= 28));
      chk("almost_empty", int'(almost_empty), int'(n <= 4));
`else
      chk("almost_full",  int'(almost_full),  0);
      chk("almost_empty", int'(almost_empty), 0);
`endif
   endtask

   // One clock of stimulus; the model decides acceptance before the edge.
   task automatic step(input logic we, input logic [7:0] d, input logic re);
      bit exp_ovf, exp_unf, racc, wacc;
      exp_ovf = we && (model.size() == DEPTH);
      exp_unf = re && (model.size() == 0);
      racc    = re && (model.size() != 0);
      wacc    = we && (model.size() != DEPTH);
      wr_en = we; din = d; rd_en = re;
      @(posedge clk);
      if (racc) exp_q.push_back(model.pop_front());
      if (wacc) model.push_back(d);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
      chk("overflow",  int'(overflow),  int'(exp_ovf));
      chk("underflow", int'(underflow), int'(exp_unf));
      check_status();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full), 0);
      chk("rst_dout",  int'(dout), 0);
      chk("rst_dv",    int'(dout_valid), 0);
      chk("rst_ovf",   int'(overflow), 0);
      chk("rst_unf",   int'(underflow), 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Fill completely, then one more write
      for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0);
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 32);
      step(1'b1, 8'hEE, 1'b0);
      chk("ovf_pulse", int'(overflow), 1);
      step(1'b0, 8'h00, 1'b0);
      chk("ovf_clear", int'(overflow), 0);
      chk("ovf_count", int'(count), 32);

      // Drain completely, then one more read
      for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);
      chk("drain_empty", int'(empty), 1);
      chk("drain_last", int'(dout), 8'h1F);
      step(1'b0, 8'h00, 1'b1);
      chk("unf_pulse", int'(underflow), 1);
      chk("unf_dv", int'(dout_valid), 0);
      chk("unf_dout", int'(dout), 8'h1F);

      // Wrap-around
      for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
      chk("wrap_last", int'(dout), 8'hB3);
      chk("wrap_count", int'(count), 0);

      // Simultaneous read/write at count=10
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 50; i++) step(1'b1, 8'(8'h60 + i), 1'b1);
      chk("rw_count", int'(count), 10);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

      // Both high at full and at empty, with watermark boundaries on the way
      for (int i = 0; i < 27; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      step(1'b1, 8'hDB, 1'b0);
      step(1'b1, 8'hDC, 1'b1);   // count stays 28
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
      step(1'b1, 8'hF5, 1'b1);
      chk("full_rw_count", int'(count), 31);
      chk("full_rw_ovf", int'(overflow), 1);
      for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h3C, 1'b1);
      chk("empty_rw_count", int'(count), 1);
      chk("empty_rw_unf", int'(underflow), 1);
      step(1'b0, 8'h00, 1'b1);
      chk("empty_rw_data", int'(dout), 8'h3C);

      // Asynchronous reset mid-burst at count=17
      for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      wr_en = 1'b1; din = 8'h77;
      #2 rst = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_dout",  int'(dout), 0);
      wr_en = 1'b0;
      model.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("arst_data", int'(dout), 8'h5A);

      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_fifo.md
# bus_fifo

Parametrised synchronous FIFO that buffers bus data between a producer and a consumer in the same clock domain. It replaces the fixed 8-bit, 32-entry buffer with configurable width and depth, and uses all DEPTH entries. It adds exported full/empty/count status, registered read data with a valid strobe, error pulses and optional watermark flags. It sits on the bus datapath wherever a producer can burst faster than its consumer drains.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 32: entry count; power of two, ≥4
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- din  in  WIDTH  write data, sampled with an accepted write
- rd_en  in  1  read request
- dout  out  WIDTH  read data, registered
- dout_valid  out  1  dout holds a newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  out  1  watermark flag, see Configuration
- almost_empty  out  1  watermark flag, see Configuration
- overflow  out  1  one-cycle pulse: write requested while full and not accepted
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- Pointers wr_ptr and rd_ptr are AW+1 bits wide, where AW = $clog2(DEPTH). The low AW bits address the memory and the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr). full = (low bits equal and MSBs differ). count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Accepted write: wr_acc = wr_en & !full. Accepted read: rd_acc = rd_en & !empty. Both are evaluated on the current-cycle state, before the edge.
- Full with wr_en and rd_en both high: the read is accepted, the write is rejected, and overflow pulses.
- Empty with wr_en and rd_en both high: the write is accepted, the read is rejected, and underflow pulses. There is no fall-through.
- Otherwise, with both accepted: the pointers both advance and count is unchanged.
- Pointers wrap naturally modulo 2^(AW+1). No special casing at DEPTH−1.
- Write data is held in the memory. Read data is registered into dout on rd_acc. dout holds its last value when no read is accepted.
- There is no state machine. Behaviour is fully defined by the pointer, count and output registers.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0. Derived: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Reset asserted mid-operation: all contents are discarded immediately, asynchronously. The first write after deassertion lands at address 0.
- Write to read latency: a word written at edge N can be popped by rd_en at edge N+1, and appears on dout with dout_valid after edge N+1.
- Read latency: rd_acc at edge N means dout and dout_valid are valid in cycle N+1. dout_valid is high for exactly one cycle per accepted read.
- full, empty, count and the watermarks are combinational from the pointers. They update in the cycle after the edge that moved the pointers.
- overflow and underflow are registered. Each is high for the single cycle following the offending edge.

## Configuration
- Macro: BUS_FIFO_WATERMARK_EN.
- Defined: almost_full = (count ≥ AF_LEVEL) and almost_empty = (count ≤ AE_LEVEL), combinational.
- Undefined: both ports still exist and are tied to 0, and the comparators are not built.
- All other behaviour is identical in both builds.

## Structure
- Package bus_fifo_pkg holds:
  - function fifo_aw(depth) returning $clog2(depth)
  - the localparam defaults for WIDTH, DEPTH, AF_LEVEL and AE_LEVEL
- Sub-module bus_fifo_mem: a DEPTH×WIDTH simple dual-port array with a synchronous write and a registered read port.
  - It owns the dout register.
  - The top owns the pointers, flags, error pulses and dout_valid.

## Test plan
All scenarios use WIDTH=8, DEPTH=32 unless stated.
- Reset, then 32 writes of 0x00..0x1F: full=1 and count=32 after the 32nd edge. A 33rd write gives overflow=1 for one cycle and count stays 32.
- From full, 32 reads: dout = 0x00..0x1F in order, each with dout_valid=1. Then empty=1. A 33rd read gives underflow=1, and dout_valid=0 with dout still 0x1F.
- Wrap-around: 20 writes, 20 reads, 20 writes (0xA0..0xB3), 20 reads: data returned is 0xA0..0xB3 and count ends at 0.
- Simultaneous read and write at count=10 for 50 cycles: count stays 10 and data order is preserved. At full with both high: count drops to 31 and overflow pulses. At empty with both high: count becomes 1 and underflow pulses.
- With BUS_FIFO_WATERMARK_EN defined: at count=28, almost_full=1; at count=27, almost_full=0; at count=4, almost_empty=1. Undefined: both flags are 0 at every occupancy.
- Assert rst at count=17, mid-burst: within the same cycle, count=0, empty=1 and dout=0. After release, a write of 0x5A followed by a read returns 0x5A.
